// File: rtl/ball_motion.sv
// Pong ball engine: owns ball position/velocity, steps once per frame tick,
// bounces off walls and paddles, and re-serves from the centre after a score.
module ball_motion #(
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 10,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int STEP_MAX    = 7,
  parameter int SERVE_DELAY = 60
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tick,
  input  logic                            serve,
  input  logic                            hit_left,
  input  logic                            hit_right,
  output logic [X_WIDTH-1:0]              ball_x,
  output logic [Y_WIDTH-1:0]              ball_y,
  output logic                            dir_x,
  output logic                            dir_y,
  output logic [$clog2(STEP_MAX+1)-1:0]   speed,
  output logic                            score_left,
  output logic                            score_right,
  output logic [1:0]                      state
);

  localparam int SW = $clog2(STEP_MAX + 1);
  localparam int CW = $clog2(SERVE_DELAY + 1);
  localparam int X_MAX_I = SCREEN_W - BALL_SIZE;
  localparam int Y_MAX_I = SCREEN_H - BALL_SIZE;

  localparam logic [X_WIDTH:0]   X_MAX = (X_WIDTH+1)'(X_MAX_I);
  localparam logic [Y_WIDTH:0]   Y_MAX = (Y_WIDTH+1)'(Y_MAX_I);
  localparam logic [X_WIDTH-1:0] X_C   = X_WIDTH'(X_MAX_I / 2);
  localparam logic [Y_WIDTH-1:0] Y_C   = Y_WIDTH'(Y_MAX_I / 2);
  localparam logic [SW-1:0]      SMAX  = SW'(STEP_MAX);
  localparam logic [SW-1:0]      SONE  = SW'(1);
  localparam logic [CW-1:0]      CLAST = CW'(SERVE_DELAY - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, SCORED = 2'd2} state_t;

  state_t             st, st_d;
  logic [X_WIDTH-1:0] x_d;
  logic [Y_WIDTH-1:0] y_d;
  logic               dx_d, dy_d, sl_d, sr_d;
  logic [SW-1:0]      spd_d;
  logic [CW-1:0]      cnt, cnt_d;

  logic               hit, ndir, x_exit;
  logic [SW-1:0]      nspd;
  logic [X_WIDTH:0]   xe, sx, nx;
  logic [Y_WIDTH:0]   ye, sy, ny;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= IDLE;
      ball_x      <= X_C;
      ball_y      <= Y_C;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      speed       <= SONE;
      score_left  <= 1'b0;
      score_right <= 1'b0;
      cnt         <= '0;
    end else begin
      st          <= st_d;
      ball_x      <= x_d;
      ball_y      <= y_d;
      dir_x       <= dx_d;
      dir_y       <= dy_d;
      speed       <= spd_d;
      score_left  <= sl_d;
      score_right <= sr_d;
      cnt         <= cnt_d;
    end
  end

  // Step arithmetic runs one bit wider than the coordinates so it never wraps.
  always_comb begin
    hit  = dir_x ? hit_right : hit_left;
    ndir = hit ? ~dir_x : dir_x;
    nspd = (hit && speed < SMAX) ? speed + SONE : speed;
    xe   = {1'b0, ball_x};
    ye   = {1'b0, ball_y};
    sx   = (X_WIDTH+1)'(nspd);
    sy   = (Y_WIDTH+1)'(nspd);

    if (ndir) begin
      x_exit = (xe + sx) >= X_MAX;
      nx     = x_exit ? X_MAX : xe + sx;
    end else begin
      x_exit = xe <= sx;
      nx     = x_exit ? '0 : xe - sx;
    end

    ny   = '0;
    dy_d = dir_y;
    if (dir_y) begin
      if ((ye + sy) >= Y_MAX) begin
        ny   = Y_MAX;
        dy_d = 1'b0;
      end else begin
        ny = ye + sy;
      end
    end else begin
      if (ye <= sy) begin
        ny   = '0;
        dy_d = 1'b1;
      end else begin
        ny = ye - sy;
      end
    end

    st_d  = st;
    x_d   = ball_x;
    y_d   = ball_y;
    dx_d  = dir_x;
    spd_d = speed;
    sl_d  = 1'b0;
    sr_d  = 1'b0;
    cnt_d = cnt;

    case (st)
      IDLE: begin
        dy_d = dir_y;
        if (serve) st_d = MOVE;
      end
      MOVE: begin
        if (tick) begin
          x_d   = nx[X_WIDTH-1:0];
          y_d   = ny[Y_WIDTH-1:0];
          dx_d  = ndir;
          spd_d = nspd;
          // A paddle hit suppresses scoring even if the step lands on an edge.
          if (x_exit && !hit) begin
            st_d = SCORED;
            sl_d = ndir;
            sr_d = ~ndir;
          end
        end else begin
          dy_d = dir_y;
        end
      end
      SCORED: begin
        dy_d = dir_y;
        if (tick) begin
          if (cnt == CLAST) begin
            st_d  = IDLE;
            x_d   = X_C;
            y_d   = Y_C;
            spd_d = SONE;
            dx_d  = ~dir_x;
            cnt_d = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      default: begin
        dy_d = dir_y;
        st_d = IDLE;
      end
    endcase
  end

  assign state = st;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: a vector table for serve/idle behaviour,
// then hand-written sequences for walls, exits, re-serve, paddles and reset.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, serve = 1'b0, hit_left = 1'b0, hit_right = 1'b0;
  logic [9:0] ball_x, ball_y;
  logic       dir_x, dir_y, score_left, score_right;
  logic [2:0] speed;
  logic [1:0] state;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ball_motion #(
    .X_WIDTH(10), .Y_WIDTH(10), .SCREEN_W(640), .SCREEN_H(480),
    .BALL_SIZE(8), .STEP_MAX(7), .SERVE_DELAY(60)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .serve(serve),
    .hit_left(hit_left), .hit_right(hit_right),
    .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y),
    .speed(speed), .score_left(score_left), .score_right(score_right),
    .state(state)
  );

  typedef struct {
    logic r, sv, tk, hl, hr;
    int   x, y;
    int   dx, dy, spd, st, sl, sr;
  } vec_t;

  vec_t tbl[9];

  // Negative expected values mean "don't care".
  task automatic check(input string name, input int x, input int y, input int dx,
                       input int dy, input int spd, input int st, input int sl,
                       input int sr);
    bit ok;
    ok = 1'b1;
    if (x   >= 0 && int'(ball_x)      != x)   ok = 1'b0;
    if (y   >= 0 && int'(ball_y)      != y)   ok = 1'b0;
    if (dx  >= 0 && int'(dir_x)       != dx)  ok = 1'b0;
    if (dy  >= 0 && int'(dir_y)       != dy)  ok = 1'b0;
    if (spd >= 0 && int'(speed)       != spd) ok = 1'b0;
    if (st  >= 0 && int'(state)       != st)  ok = 1'b0;
    if (sl  >= 0 && int'(score_left)  != sl)  ok = 1'b0;
    if (sr  >= 0 && int'(score_right) != sr)  ok = 1'b0;
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d dx=%0d dy=%0d spd=%0d st=%0d sl=%0d sr=%0d ; want x=%0d y=%0d dx=%0d dy=%0d spd=%0d st=%0d sl=%0d sr=%0d",
               name, ball_x, ball_y, dir_x, dir_y, speed, state, score_left,
               score_right, x, y, dx, dy, spd, st, sl, sr);
    end
  endtask

  task automatic cyc(input logic sv, input logic tk, input logic hl, input logic hr);
    @(negedge clk);
    serve = sv; tick = tk; hit_left = hl; hit_right = hr;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; serve = 1'b0; tick = 1'b0; hit_left = 1'b0; hit_right = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    //           r     sv    tk    hl    hr     x    y   dx dy spd st sl sr
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 316, 236, 1, 1, 1, 0, 0, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 316, 236, 1, 1, 1, 0, 0, 0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 316, 236, 1, 1, 1, 0, 0, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 316, 236, 1, 1, 1, 1, 0, 0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 317, 237, 1, 1, 1, 1, 0, 0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 318, 238, 1, 1, 1, 1, 0, 0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 318, 238, 1, 1, 1, 1, 0, 0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 319, 239, 1, 1, 1, 1, 0, 0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 320, 240, 1, 1, 1, 1, 0, 0};

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rst = tbl[i].r; serve = tbl[i].sv; tick = tbl[i].tk;
      hit_left = tbl[i].hl; hit_right = tbl[i].hr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].dx, tbl[i].dy,
            tbl[i].spd, tbl[i].st, tbl[i].sl, tbl[i].sr);
    end

    // Bottom wall, right exit, score pulse, serve delay and re-serve.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(236);
    check("wall_hit", 552, 472, 1, 0, 1, 1, 0, 0);
    ticks(1);
    check("wall_after", 553, 471, 1, 0, 1, 1, 0, 0);
    ticks(78);
    check("pre_exit", 631, 393, 1, 0, 1, 1, 0, 0);
    ticks(1);
    check("exit_right", 632, 392, 1, 0, 1, 2, 1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("score_pulse_end", 632, 392, 1, 0, 1, 2, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("serve_in_scored", 632, 392, 1, 0, 1, 2, 0, 0);
    ticks(59);
    check("delay_59", 632, 392, 1, 0, 1, 2, 0, 0);
    ticks(1);
    check("reserve_idle", 316, 236, 0, 0, 1, 0, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(1);
    check("reserve_move", 315, 235, 0, 0, 1, 1, 0, 0);
    ticks(314);
    check("pre_exit_left", 1, -1, 0, -1, 1, 1, 0, 0);
    ticks(1);
    check("exit_left", 0, -1, 0, -1, 1, 2, 0, 1);

    // Paddle bounces and speed saturation.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(184);
    check("paddle_pre", 500, 420, 1, 1, 1, 1, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("paddle_right", 498, -1, 0, -1, 2, 1, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("paddle_ignored", 496, -1, 0, -1, 2, 1, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("paddle_l3", 499, -1, 1, -1, 3, 1, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("paddle_both4", 495, -1, 0, -1, 4, 1, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("paddle_l5", 500, -1, 1, -1, 5, 1, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("paddle_r6", 494, -1, 0, -1, 6, 1, 0, 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("paddle_l7", 501, -1, 1, -1, 7, 1, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("paddle_sat", 494, -1, 0, -1, 7, 1, 0, 0);

    // Asynchronous reset mid-move, observed between clock edges.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(84);
    check("pre_async_rst", 400, 320, 1, 1, 1, 1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", 316, 236, 1, 1, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1; tick = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
